// File: rtl/mcu2pc_uart_tx_if.sv
// Byte-write / status / serial-line bundle between the MCU side and the UART transmitter.
interface mcu2pc_uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_dat;
    logic [2:0]    tx_baud;
    logic          full;
    logic          empty;
    logic [CW-1:0] fifo_cnt;
    logic          ovf;
    logic          tx;
    logic          tx_ing;
    logic          tx_ok;

    modport master (
        output wr_en, wr_dat, tx_baud,
        input  full, empty, fifo_cnt, ovf, tx, tx_ing, tx_ok
    );

    modport slave (
        input  wr_en, wr_dat, tx_baud,
        output full, empty, fifo_cnt, ovf, tx, tx_ing, tx_ok
    );
endinterface

// File: rtl/mcu2pc_uart_tx.sv
// MCU-to-PC UART transmitter: byte FIFO feeding an 8N1 serializer with selectable baud rate.
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for DIV cycles
// DATA  | 8 data bits, LSB first, DIV cycles each
// STOP  | stop bit (high) for DIV cycles; back-to-back pop on its last cycle
module mcu2pc_uart_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    mcu2pc_uart_tx_if.slave          bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // DIV below 16 (fast baud at a slow clock) is a configuration error and is not trapped here.
    function automatic logic [15:0] div_for(input logic [2:0] sel);
        int baud;
        case (sel)
            3'd0:    baud = 9600;
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            3'd4:    baud = 115200;
            3'd5:    baud = 230400;
            3'd6:    baud = 460800;
            default: baud = 921600;
        endcase
        return 16'(CLK_HZ / baud);
    endfunction

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q;

    state_t        state_q;
    logic [15:0]   tmr_q;
    logic [15:0]   div_q;
    logic [2:0]    bit_q;
    logic [7:0]    shf_q;
    logic          tx_q, tx_ing_q, tx_ok_q;

    logic          full, empty, push, pop;
    logic [15:0]   div_sel;

    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign push    = bus.wr_en & ~full;
    assign pop     = ~empty & ((state_q == IDLE) | ((state_q == STOP) & (tmr_q == 16'd0)));
    assign div_sel = div_for(bus.tx_baud);

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_dat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= bus.wr_en & full;
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            shf_q    <= '0;
            tx_q     <= 1'b1;
            tx_ing_q <= 1'b0;
            tx_ok_q  <= 1'b0;
        end else begin
            tx_ok_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shf_q    <= mem_q[rd_ptr_q];
                        div_q    <= div_sel;
                        tmr_q    <= div_sel - 16'd1;
                        tx_q     <= 1'b0;
                        tx_ing_q <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (tmr_q == 16'd0) begin
                        tmr_q   <= div_q - 16'd1;
                        bit_q   <= '0;
                        tx_q    <= shf_q[0];
                        state_q <= DATA;
                    end else begin
                        tmr_q <= tmr_q - 16'd1;
                    end
                end
                DATA: begin
                    if (tmr_q == 16'd0) begin
                        tmr_q <= div_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            shf_q <= {1'b0, shf_q[7:1]};
                            tx_q  <= shf_q[1];
                        end
                    end else begin
                        tmr_q <= tmr_q - 16'd1;
                    end
                end
                STOP: begin
                    // registered pulse lands on the final stop cycle
                    tx_ok_q <= (tmr_q == 16'd1);
                    if (tmr_q == 16'd0) begin
                        if (pop) begin
                            shf_q   <= mem_q[rd_ptr_q];
                            div_q   <= div_sel;
                            tmr_q   <= div_sel - 16'd1;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_ing_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end else begin
                        tmr_q <= tmr_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.fifo_cnt = cnt_q;
    assign bus.ovf      = ovf_q;
    assign bus.tx       = tx_q;
    assign bus.tx_ing   = tx_ing_q;
    assign bus.tx_ok    = tx_ok_q;
endmodule

// File: tb/tb_mcu2pc_uart_tx.sv
// Directed bench for mcu2pc_uart_tx at 50 MHz: latency, framing, burst, overflow, baud change, reset abort.
module tb_mcu2pc_uart_tx;
    logic clk = 1'b0;
    logic rstn;
    int   n_chk  = 0;
    int   n_fail = 0;

    mcu2pc_uart_tx_if #(.FIFO_DEPTH(16)) bus();

    mcu2pc_uart_tx #(.CLK_HZ(50000000), .FIFO_DEPTH(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.wr_en  = 1'b1;
        bus.wr_dat = d;
        tick();
        bus.wr_en  = 1'b0;
    endtask

    // Called in cycle c0 of a frame (0 = first start-bit cycle); returns in its last stop cycle.
    task automatic check_frame(input logic [7:0] d, input int div, input int c0);
        int  ok_n;
        int  b;
        logic e;
        ok_n = 0;
        for (int c = c0; c < 10 * div; c++) begin
            b = c / div;
            if (b == 0)      e = 1'b0;
            else if (b == 9) e = 1'b1;
            else             e = d[b-1];
            if ((c % div == 0) || (c % div == div - 1))
                check($sformatf("frame_%02h_c%0d_tx", d, c), 32'(bus.tx), 32'(e));
            if (c == c0) check($sformatf("frame_%02h_tx_ing", d), 32'(bus.tx_ing), 32'd1);
            ok_n += int'(bus.tx_ok);
            if (c < 10 * div - 1) tick();
        end
        check($sformatf("frame_%02h_tx_ok_last", d), 32'(bus.tx_ok), 32'd1);
        check($sformatf("frame_%02h_tx_ok_count", d), 32'(ok_n), 32'd1);
    endtask

    task automatic rx_byte(input int div, output logic [7:0] d);
        int w;
        w = 0;
        d = 8'h00;
        while (bus.tx !== 1'b0 && w < 12 * div) begin
            tick();
            w++;
        end
        check("rx_start_seen", 32'(bus.tx === 1'b0), 32'd1);
        repeat (div / 2) tick();
        for (int i = 0; i < 8; i++) begin
            repeat (div) tick();
            d[i] = bus.tx;
        end
        repeat (div) tick();
        check("rx_stop_bit", 32'(bus.tx), 32'd1);
    endtask

    initial begin
        logic [7:0] rb;
        int         bad;
        rstn        = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_dat  = 8'h00;
        bus.tx_baud = 3'd4;
        repeat (3) tick();
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_tx_ing", 32'(bus.tx_ing), 32'd0);
        check("rst_tx_ok", 32'(bus.tx_ok), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_cnt", 32'(bus.fifo_cnt), 32'd0);

        // single byte, written in the same cycle reset is released
        rstn = 1'b1;
        wr(8'h55);
        check("lat_k1_cnt", 32'(bus.fifo_cnt), 32'd1);
        check("lat_k1_tx", 32'(bus.tx), 32'd1);
        tick();
        check_frame(8'h55, 434, 0);
        tick();
        check("single_after_tx_ing", 32'(bus.tx_ing), 32'd0);
        check("single_after_tx", 32'(bus.tx), 32'd1);
        check("single_after_tx_ok", 32'(bus.tx_ok), 32'd0);
        repeat (20) tick();

        // burst of three, contiguous frames
        wr(8'h01);
        wr(8'h80);
        wr(8'hFF);
        check_frame(8'h01, 434, 1);
        tick();
        check_frame(8'h80, 434, 0);
        tick();
        check_frame(8'hFF, 434, 0);
        tick();
        check("burst_end_tx_ing", 32'(bus.tx_ing), 32'd0);
        check("burst_end_empty", 32'(bus.empty), 32'd1);
        repeat (20) tick();

        // baud change mid-frame
        wr(8'hA5);
        wr(8'h3C);
        bus.tx_baud = 3'd7;
        check_frame(8'hA5, 434, 0);
        tick();
        check_frame(8'h3C, 54, 0);
        tick();
        check("baud_end_tx_ing", 32'(bus.tx_ing), 32'd0);
        repeat (20) tick();

        // overflow while a frame holds the line (DIV=54)
        wr(8'hEE);
        for (int i = 0; i <= 16; i++) begin
            wr(8'(i));
            check($sformatf("ovf_wr_%02h", i), 32'(bus.ovf), 32'(i == 16));
        end
        check("ovf_cnt", 32'(bus.fifo_cnt), 32'd16);
        check("ovf_full", 32'(bus.full), 32'd1);
        tick();
        check("ovf_pulse_end", 32'(bus.ovf), 32'd0);
        rx_byte(54, rb);
        check("ovf_rx_EE", 32'(rb), 32'hEE);
        for (int i = 0; i < 16; i++) begin
            rx_byte(54, rb);
            check($sformatf("ovf_rx_%02h", i), 32'(rb), 32'(i));
        end
        bad = 0;
        repeat (1500) begin
            tick();
            if (bus.tx !== 1'b1) bad++;
        end
        check("ovf_idle_line", 32'(bad), 32'd0);
        check("ovf_idle_empty", 32'(bus.empty), 32'd1);

        // reset abort during data bit 3 of 0xC3
        bus.tx_baud = 3'd4;
        wr(8'hC3);
        wr(8'h11);
        wr(8'h22);
        repeat (434 * 4 + 199) tick();
        check("abort_pre_tx_bit3", 32'(bus.tx), 32'd0);
        check("abort_pre_cnt", 32'(bus.fifo_cnt), 32'd2);
        check("abort_pre_tx_ing", 32'(bus.tx_ing), 32'd1);
        rstn = 1'b0;
        #1;
        check("abort_tx", 32'(bus.tx), 32'd1);
        check("abort_cnt", 32'(bus.fifo_cnt), 32'd0);
        check("abort_tx_ing", 32'(bus.tx_ing), 32'd0);
        check("abort_empty", 32'(bus.empty), 32'd1);
        repeat (3) tick();
        rstn = 1'b1;
        bad = 0;
        repeat (5000) begin
            tick();
            if (bus.tx !== 1'b1 || bus.tx_ok !== 1'b0 || bus.tx_ing !== 1'b0) bad++;
        end
        check("abort_line_idle", 32'(bad), 32'd0);
        check("abort_cnt_after", 32'(bus.fifo_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mcu2pc_uart_tx.md
MCU2PC_UART_TX -- requirements
Module: mcu2pc_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO depth in bytes; power of two, minimum 2.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port wr_en, input, 1, one-cycle byte write strobe from the MCU side.
REQ-007 SHALL have port wr_dat, input, 8, byte written when wr_en=1.
REQ-008 SHALL have port tx_baud, input, 3, baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600.
REQ-009 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port empty, output, 1, FIFO holds 0 bytes.
REQ-011 SHALL have port fifo_cnt, output, log2(FIFO_DEPTH)+1, bytes currently stored.
REQ-012 SHALL have port ovf, output, 1, one-cycle pulse when a write is dropped.
REQ-013 SHALL have port tx, output, 1, serial line toward the PC; idle high.
REQ-014 SHALL have port tx_ing, output, 1, frame in progress.
REQ-015 SHALL have port tx_ok, output, 1, one-cycle pulse at frame end.

Function
REQ-016 Bit period DIV SHALL be CLK_HZ/baud, integer-truncated, from a 16-bit counter; DIV<16 is a configuration error.
REQ-017 FIFO write SHALL be accepted when wr_en=1 and full=0; when full=1, the byte SHALL be discarded, FIFO contents kept, and ovf pulsed for that cycle, even if a pop occurs in the same cycle.
REQ-018 Simultaneous accepted write and pop SHALL leave fifo_cnt unchanged; FIFO order SHALL be first-in first-out; pointers wrap modulo FIFO_DEPTH.
REQ-019 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-020 IDLE: tx=1. When empty=0, the FSM SHALL pop one byte into the shift register, latch DIV from tx_baud, and enter START.
REQ-021 START: tx=0 for exactly DIV cycles, then enter DATA.
REQ-022 DATA: 8 bits sent LSB first, each for exactly DIV cycles, with a 3-bit bit index; after bit 7, enter STOP.
REQ-023 STOP: tx=1 for exactly DIV cycles; tx_ok=1 on the last STOP cycle.
REQ-024 On the last STOP cycle with empty=0, the FSM SHALL pop, relatch DIV, and enter START directly, leaving no idle gap. Otherwise it SHALL enter IDLE.
REQ-025 tx_baud changes mid-frame SHALL NOT affect the current frame; the new rate applies from the next START.
REQ-026 Latency: wr_en high in cycle k into an empty FIFO with the FSM in IDLE SHALL produce tx=0 starting in cycle k+2.
REQ-027 tx_ing SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-028 tx, tx_ing, tx_ok, ovf SHALL be registered outputs.

Reset
REQ-029 On rstn=0, asynchronously: FSM=IDLE, tx=1, tx_ing=0, tx_ok=0, ovf=0, FIFO pointers=0, fifo_cnt=0, empty=1, full=0, counters=0.
REQ-030 Reset mid-frame SHALL abort the frame and drive tx=1 immediately; queued bytes SHALL be lost.
REQ-031 After rstn deasserts, the first wr_en SHALL be honoured on the next rising edge.

Verification (CLK_HZ=50000000, tx_baud=4, DIV=434)
REQ-032 Single byte: write 0x55 in cycle k -> tx low in cycle k+2; line pattern 0,1,0,1,0,1,0,1,0,1 at 434 cycles per bit; tx_ok pulses once 4340 cycles after the start bit; tx_ing=0 afterwards.
REQ-033 Burst: write 0x01,0x80,0xFF back-to-back -> three contiguous frames of 4340 cycles each, no idle gap; 3 tx_ok pulses; empty=1 at the end.
REQ-034 Overflow: with transmission stalled mid-frame, write 17 bytes (0x00..0x10) -> fifo_cnt=16, full=1, ovf pulses only on 0x10; transmitted order is 0x00..0x0F, then idle.
REQ-035 Baud change: start 0xA5 at tx_baud=4, switch to 7 mid-frame -> current frame keeps 434-cycle bits; next queued frame uses 54-cycle bits.
REQ-036 Reset abort: assert rstn=0 during DATA bit 3 of 0xC3 with 2 bytes queued -> tx=1, fifo_cnt=0, tx_ing=0 immediately; no tx_ok; line stays idle after release.
